// File: rtl/ws2811_frame_sequencer.sv
// WS2811 frame sequencer: walks the pixel RAM, reorders colour channels,
// and feeds each pixel to the bit transmitter through its start/busy
// handshake. After the last pixel it holds the line idle for the latch time
// and then pulses frameDoneOUT.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for frameStartIN
// S_FETCH    | RAM address presented, waiting out the read latency
// S_LOAD     | capture RAM data into txDataOUT in the configured order
// S_START    | pulse txStartOUT as soon as the transmitter is free
// S_WAIT_ACK | waiting for the transmitter to raise busy
// S_WAIT_DONE| waiting for the transmitter to drop busy
// S_LATCH    | line held idle for the latch time before frame done
module ws2811_frame_sequencer #(
  parameter int CLOCK_SPEED = 50_000_000,
  parameter int PIXEL_COUNT = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int LATCH_US    = 60,
  parameter int COLOR_ORDER = 1
) (
  input  logic                  clkIN,
  input  logic                  nResetIN,
  input  logic                  frameStartIN,
  output logic [ADDR_WIDTH-1:0] memAddrOUT,
  input  logic [23:0]           memDataIN,
  input  logic                  txBusyIN,
  output logic                  txStartOUT,
  output logic [23:0]           txDataOUT,
  output logic                  busyOUT,
  output logic                  frameDoneOUT
);

  localparam int LATCH_CYCLES = CLOCK_SPEED / 1_000_000 * LATCH_US;
  localparam logic [19:0] LATCH_LAST = 20'(LATCH_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_LATCH
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [23:0]             data_next;
  logic [23:0]             pixel_ordered;
  logic                    busy_next;
  logic [19:0]             latch_cnt;
  logic [19:0]             latch_cnt_next;

  // Channel reordering of the RAM word; order 1 swaps red and green.
  always_comb begin
    if (COLOR_ORDER == 1) begin
      pixel_ordered = {memDataIN[15:8], memDataIN[23:16], memDataIN[7:0]};
    end else begin
      pixel_ordered = memDataIN;
    end
  end

  // State register plus the registered address, pixel, busy and latch count.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state      <= S_IDLE;
      memAddrOUT <= '0;
      txDataOUT  <= '0;
      busyOUT    <= 1'b0;
      latch_cnt  <= '0;
    end else begin
      state      <= state_next;
      memAddrOUT <= addr_next;
      txDataOUT  <= data_next;
      busyOUT    <= busy_next;
      latch_cnt  <= latch_cnt_next;
    end
  end

  // Next-state logic with the start and frame-done strobes decoded from state.
  always_comb begin
    state_next     = state;
    addr_next      = memAddrOUT;
    data_next      = txDataOUT;
    busy_next      = busyOUT;
    latch_cnt_next = latch_cnt;
    txStartOUT     = 1'b0;
    frameDoneOUT   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frameStartIN) begin
          addr_next  = '0;
          busy_next  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        data_next  = pixel_ordered;
        state_next = S_START;
      end
      S_START: begin
        // Never strobe into a transmitter that still reports busy.
        if (!txBusyIN) begin
          txStartOUT = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (txBusyIN) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!txBusyIN) begin
          if (memAddrOUT == LAST_ADDR) begin
            latch_cnt_next = '0;
            state_next     = S_LATCH;
          end else begin
            addr_next  = memAddrOUT + ADDR_WIDTH'(1);
            state_next = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          frameDoneOUT = 1'b1;
          busy_next    = 1'b0;
          state_next   = S_IDLE;
        end else begin
          latch_cnt_next = latch_cnt + 20'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Bench for ws2811_frame_sequencer. The main instance (4 pixels, G/R/B order,
// 3000-cycle latch) is followed cycle by cycle by a frame-level model; a
// second instance (1 pixel, R/G/B order, 50-cycle latch) gets directed checks.
module tb_ws2811_frame_sequencer;

  localparam int PC        = 4;
  localparam int LATCH     = 3000;
  localparam int TX_CYCLES = 1250;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        fs = 1'b0;
  logic [5:0]  mem_addr;
  logic [23:0] mem_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_hold = 1'b0;
  logic        tx_busy_in;
  logic        tx_start;
  logic [23:0] tx_data;
  logic        busy_o;
  logic        done_o;

  logic        fs0 = 1'b0;
  logic [5:0]  addr0;
  logic [23:0] data0_in = '0;
  logic        tx_busy0 = 1'b0;
  logic        start0;
  logic [23:0] txdata0;
  logic        busyo0;
  logic        done0;

  logic [23:0] ram [0:63];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // frame model state
  logic        busy_exp = 1'b0;
  logic        pend = 1'b0;
  logic        inflight = 1'b0;
  logic        armed = 1'b0;
  logic        prev_busy = 1'b0;
  int          due = 0;
  int          idx = 0;
  int          fall_cyc = 0;
  int          done_gap = -1;
  int          n_starts_seen = 0;
  logic [23:0] cur = '0;
  logic [23:0] seen_q[$];

  assign tx_busy_in = tx_busy | tx_hold;

  always #10 clk = ~clk;

  ws2811_frame_sequencer #(
    .CLOCK_SPEED(50_000_000), .PIXEL_COUNT(PC), .ADDR_WIDTH(6),
    .LATCH_US(60), .COLOR_ORDER(1)
  ) u_dut (
    .clkIN(clk), .nResetIN(rst_n), .frameStartIN(fs),
    .memAddrOUT(mem_addr), .memDataIN(mem_data), .txBusyIN(tx_busy_in),
    .txStartOUT(tx_start), .txDataOUT(tx_data), .busyOUT(busy_o),
    .frameDoneOUT(done_o)
  );

  ws2811_frame_sequencer #(
    .CLOCK_SPEED(50_000_000), .PIXEL_COUNT(1), .ADDR_WIDTH(6),
    .LATCH_US(1), .COLOR_ORDER(0)
  ) u_dut0 (
    .clkIN(clk), .nResetIN(rst_n), .frameStartIN(fs0),
    .memAddrOUT(addr0), .memDataIN(data0_in), .txBusyIN(tx_busy0),
    .txStartOUT(start0), .txDataOUT(txdata0), .busyOUT(busyo0),
    .frameDoneOUT(done0)
  );

  // synchronous pixel RAMs, one cycle of read latency
  always_ff @(posedge clk) begin
    mem_data <= ram[mem_addr];
    data0_in <= (addr0 == 6'd0) ? 24'hA5C33C : 24'h000000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] wire_order(input logic [23:0] px, input int order);
    logic [7:0] r, g, b;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    return (order == 1) ? {g, r, b} : {r, g, b};
  endfunction

  // transmitter models: busy rises the edge after a start, holds a fixed time
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (TX_CYCLES) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (start0) begin
      @(posedge clk); #1 tx_busy0 = 1'b1;
      repeat (20) @(posedge clk);
      #1 tx_busy0 = 1'b0;
    end
  end

  // Frame-level model and per-cycle comparison for the main instance.
  // Timing rules: first start 3 cycles after a request is seen (or later
  // while the transmitter is busy), next start 3 cycles after busy falls,
  // frame done LATCH cycles after the last busy fall, busy output from the
  // cycle after acceptance to the cycle after frame done.
  initial forever begin
    logic start_exp, done_exp, busy_nx;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      busy_exp = 1'b0; pend = 1'b0; inflight = 1'b0; armed = 1'b0;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
    end else begin
      start_exp = pend && (cyc >= due) && !tx_busy_in;
      done_exp  = armed && (cyc == fall_cyc + LATCH);
      check("tx_start", 32'(tx_start), 32'(start_exp));
      check("frame_done", 32'(done_o), 32'(done_exp));
      check("busy", 32'(busy_o), 32'(busy_exp));
      busy_nx = busy_exp;
      if (tx_start) n_starts_seen++;
      if (inflight) begin
        check("addr_hold", 32'(mem_addr), 32'(idx));
        check("data_hold", 32'(tx_data), 32'(cur));
      end
      if (inflight && prev_busy && !tx_busy_in) begin
        inflight = 1'b0;
        if (idx == PC - 1) begin
          armed = 1'b1;
          fall_cyc = cyc;
        end else begin
          idx++;
          pend = 1'b1;
          due = cyc + 3;
        end
      end
      if (start_exp) begin
        cur = wire_order(ram[idx], 1);
        check("start_addr", 32'(mem_addr), 32'(idx));
        check("start_data", 32'(tx_data), 32'(cur));
        seen_q.push_back(tx_data);
        pend = 1'b0;
        inflight = 1'b1;
      end
      if (done_exp) begin
        armed = 1'b0;
        busy_nx = 1'b0;
        done_gap = cyc - fall_cyc;
      end
      if (fs && !busy_exp) begin
        busy_nx = 1'b1;
        pend = 1'b1;
        due = cyc + 3;
        idx = 0;
        n_starts_seen = 0;
        seen_q.delete();
      end
      busy_exp = busy_nx;
    end
    prev_busy = tx_busy_in;
  end

  task automatic pulse_fs();
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int lim);
    int k;
    k = 0;
    while (n_starts_seen < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("wait_starts", 32'(n_starts_seen >= n), 32'd1);
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (!done_o && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("wait_done", 32'(done_o), 32'd1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) ram[i] = 24'h112233 + 24'(i);

    // reset, then a long idle stretch
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("idle_addr", 32'(mem_addr), 32'd0);
    check("idle_data", 32'(tx_data), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);

    // single-pixel instance, channels passed through unchanged
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!start0 && k < 20) begin @(negedge clk); k++; end
    check("d0_start_seen", 32'(start0), 32'd1);
    check("d0_data", 32'(txdata0), 32'hA5C33C);
    check("d0_addr", 32'(addr0), 32'd0);
    k = 0;
    while (!tx_busy0 && k < 5) begin @(negedge clk); k++; end
    k = 0;
    while (tx_busy0 && k < 40) begin @(negedge clk); k++; end
    check("d0_tx_fell", 32'(tx_busy0), 32'd0);
    k = 0;
    while (!done0 && k < 100) begin @(negedge clk); k++; end
    check("d0_latch_gap", 32'(k), 32'd50);
    @(negedge clk);
    check("d0_busy_after", 32'(busyo0), 32'd0);

    // frame A with an ignored request during WAIT_DONE of pixel 2
    pulse_fs();
    wait_starts(2, 4000);
    repeat (100) @(posedge clk);
    pulse_fs();
    wait_done(12000);
    #1 fs = 1'b1;
    check("frameA_starts", 32'(n_starts_seen), 32'd4);
    check("frameA_count", 32'(seen_q.size()), 32'd4);
    if (seen_q.size() == 4) begin
      check("frameA_px0", 32'(seen_q[0]), 32'h221133);
      check("frameA_px1", 32'(seen_q[1]), 32'h221134);
      check("frameA_px2", 32'(seen_q[2]), 32'h221135);
      check("frameA_px3", 32'(seen_q[3]), 32'h221136);
    end
    check("frameA_latch_gap", 32'(done_gap), 32'd3000);
    @(posedge clk); #1 fs = 1'b0;
    @(negedge clk);
    check("frameA_busy_low", 32'(busy_o), 32'd0);

    // frame B: request two cycles after done, transmitter held busy on START
    @(posedge clk); #1 fs = 1'b1;
    @(posedge clk); #1 fs = 1'b0;
    tx_hold = 1'b1;
    repeat (50) @(posedge clk);
    check("stall_no_start", 32'(n_starts_seen), 32'd0);
    check("stall_busy", 32'(busy_o), 32'd1);
    #1 tx_hold = 1'b0;
    @(negedge clk);
    check("stall_release_start", 32'(tx_start), 32'd1);

    // reset during pixel 2 of frame B
    wait_starts(2, 4000);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_start", 32'(tx_start), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    while (tx_busy && k < 2000) begin @(negedge clk); k++; end
    check("tx_idle_after_abort", 32'(tx_busy), 32'd0);

    // frame C restarts from RAM[0]
    pulse_fs();
    k = 0;
    @(negedge clk);
    while (!tx_start && k < 20) begin @(negedge clk); k++; end
    check("restart_start", 32'(tx_start), 32'd1);
    check("restart_data", 32'(tx_data), 32'h221133);
    check("restart_addr", 32'(mem_addr), 32'd0);
    wait_done(12000);
    check("frameC_starts", 32'(n_starts_seen), 32'd4);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // overall time limit
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached, got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
